// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one borrow register.
// Define SUB_SIGNED_OVF_EN to add the signed overflow output Ovf.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borr
`ifdef SUB_SIGNED_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_d;
  logic             r_br;
  logic [WIDTH-1:0] r_diff;
  logic             r_borr;

  logic             w_a0;
  logic             w_b0;
  logic             w_d;
  logic             w_br;
  logic             w_last;
  logic [WIDTH-1:0] w_dnext;

  assign w_a0   = r_a[0];
  assign w_b0   = r_b[0];
  assign w_d    = w_a0 ^ w_b0 ^ r_br;
  assign w_br   = (~w_a0 & w_b0)
                | (~w_a0 & r_br)
                | (w_b0 & r_br);
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // New bit enters at the MSB; written as shifts so WIDTH=1 needs no slice.
  assign w_dnext = (r_d >> 1)
                 | (WIDTH'(w_d) << (WIDTH - 1));

`ifdef SUB_SIGNED_OVF_EN
  logic r_as;
  logic r_bs;
  logic r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_as  <= 1'b0;
      r_bs  <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      if (start && (r_state != S_SHIFT)) begin
        r_as <= A[WIDTH-1];
        r_bs <= B[WIDTH-1];
      end
      if ((r_state == S_SHIFT) && w_last) begin
        r_ovf <= (r_as ^ r_bs)
               & (w_dnext[WIDTH-1] ^ r_as);
      end
    end
  end

  assign Ovf = r_ovf;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_d     <= '0;
      r_br    <= 1'b0;
      r_diff  <= '0;
      r_borr  <= 1'b0;
    end else begin
      unique case (r_state)
        S_SHIFT: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_d   <= w_dnext;
          r_br  <= w_br;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_diff  <= w_dnext;
            r_borr  <= w_br;
            r_state <= S_DONE;
          end
        end
        S_IDLE, S_DONE: begin
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_br    <= Bin;
            r_cnt   <= '0;
            r_state <= S_SHIFT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state == S_SHIFT);
  assign done = (r_state == S_DONE);
  assign Diff = r_diff;
  assign Borr = r_borr;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8 and WIDTH=1.
// Ovf checks are enabled together with SUB_SIGNED_OVF_EN.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       st8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       bin8 = 1'b0;
  logic       busy8;
  logic       done8;
  logic [7:0] diff8;
  logic       borr8;
  logic       ovf8;

  logic       st1 = 1'b0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       bin1 = 1'b0;
  logic       busy1;
  logic       done1;
  logic [0:0] diff1;
  logic       borr1;
  logic       ovf1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (st8),
    .A     (a8),
    .B     (b8),
    .Bin   (bin8),
    .busy  (busy8),
    .done  (done8),
    .Diff  (diff8),
    .Borr  (borr8)
`ifdef SUB_SIGNED_OVF_EN
    ,
    .Ovf   (ovf8)
`endif
  );

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (st1),
    .A     (a1),
    .B     (b1),
    .Bin   (bin1),
    .busy  (busy1),
    .done  (done1),
    .Diff  (diff1),
    .Borr  (borr1)
`ifdef SUB_SIGNED_OVF_EN
    ,
    .Ovf   (ovf1)
`endif
  );

`ifndef SUB_SIGNED_OVF_EN
  assign ovf8 = 1'b0;
  assign ovf1 = 1'b0;
`endif

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // inj: pulse start with other operands 3 cycles into SHIFT
  task automatic run8(input string tag,
                      input logic [7:0] a,
                      input logic [7:0] b,
                      input logic bin,
                      input logic [7:0] ed,
                      input logic eb,
                      input logic eo,
                      input logic [7:0] prev,
                      input bit inj);
    int i;
    @(negedge clk);
    st8 = 1'b1; a8 = a; b8 = b; bin8 = bin;
    @(posedge clk);
    #1;
    st8 = 1'b0;
    a8 = ~a; b8 = ~b; bin8 = ~bin;
    chk({tag, "_busy"}, busy8, 1'b1);
    for (i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done8) break;
      if (inj && i == 3) begin
        st8 = 1'b1; a8 = 8'h10; b8 = 8'h01;
      end
      if (inj && i == 4) begin
        st8 = 1'b0;
        chk({tag, "_hold"}, diff8, prev);
      end
    end
    chk({tag, "_lat"}, i, 8);
    chk({tag, "_nbusy"}, busy8, 1'b0);
    chk({tag, "_diff"}, diff8, ed);
    chk({tag, "_borr"}, borr8, eb);
`ifdef SUB_SIGNED_OVF_EN
    chk({tag, "_ovf"}, ovf8, eo);
`else
    if (eo !== eo) chk({tag, "_ovf"}, ovf8, eo);
`endif
  endtask

  task automatic run1(input int v);
    int i;
    int full;
    logic a, b, bin;
    a = v[2]; b = v[1]; bin = v[0];
    full = int'(a) - int'(b) - int'(bin);
    @(negedge clk);
    st1 = 1'b1; a1 = a; b1 = b; bin1 = bin;
    @(posedge clk);
    #1;
    st1 = 1'b0;
    for (i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (done1) break;
    end
    chk($sformatf("w1_%0d_lat", v), i, 1);
    chk($sformatf("w1_%0d_diff", v), diff1, full & 1);
    chk($sformatf("w1_%0d_borr", v), borr1, full < 0);
`ifdef SUB_SIGNED_OVF_EN
    chk($sformatf("w1_%0d_ovf", v), ovf1,
        (a ^ b) & ((full & 1) ^ a));
`endif
  endtask

  initial begin
    int i;
    int gap;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy8, 1'b0);
    chk("rst_done", done8, 1'b0);
    chk("rst_diff", diff8, 8'h00);
    chk("rst_borr", borr8, 1'b0);
    chk("rst_ovf", ovf8, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run8("t05m03", 8'h05, 8'h03, 1'b0,
         8'h02, 1'b0, 1'b0, 8'h00, 1'b0);
    run8("t00m01", 8'h00, 8'h01, 1'b0,
         8'hFF, 1'b1, 1'b0, 8'h02, 1'b0);
    run8("tFFmFF", 8'hFF, 8'hFF, 1'b1,
         8'hFF, 1'b1, 1'b0, 8'hFF, 1'b0);
    run8("ign", 8'h05, 8'h03, 1'b0,
         8'h02, 1'b0, 1'b0, 8'hFF, 1'b1);
    run8("t80m01", 8'h80, 8'h01, 1'b0,
         8'h7F, 1'b0, 1'b1, 8'h02, 1'b0);
    run8("t7FmFF", 8'h7F, 8'hFF, 1'b0,
         8'h80, 1'b1, 1'b1, 8'h7F, 1'b0);

    for (int v = 0; v < 8; v++) run1(v);

    // start held high: one result every WIDTH+1 cycles
    @(negedge clk);
    st8 = 1'b1; a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0;
    @(posedge clk);
    #1;
    for (i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done8) break;
    end
    chk("b2b_lat1", i, 8);
    for (gap = 1; gap <= 40; gap++) begin
      @(posedge clk);
      #1;
      if (done8) break;
    end
    st8 = 1'b0;
    chk("b2b_gap", gap, 9);
    chk("b2b_diff", diff8, 8'h02);

    // async reset in the middle of SHIFT
    @(negedge clk);
    st8 = 1'b1; a8 = 8'h55; b8 = 8'h22;
    @(posedge clk);
    #1;
    st8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_busy", busy8, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("ar_busy", busy8, 1'b0);
    chk("ar_done", done8, 1'b0);
    chk("ar_diff", diff8, 8'h00);
    chk("ar_borr", borr8, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run8("t10m01", 8'h10, 8'h01, 1'b0,
         8'h0F, 1'b0, 1'b0, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
